lamp_ramp_ctrl: RTL and testbench



---
 rtl/lamp_pkg.sv | 17 +
 rtl/lamp_thermometer.sv | 18 +
 rtl/lamp_ramp_ctrl.sv | 162 ++++++++++++++++
 tb/tb_lamp_ramp_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/lamp_pkg.sv
// Shared types and helpers for the lamp ramp controller.
package lamp_pkg;

    // Controller states: settled, stepping upward, stepping downward.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RAMP_UP   = 2'd1,
        RAMP_DOWN = 2'd2
    } lamp_state_t;

    // Clamp a requested lamp count to the number of lamps physically present.
    function automatic int unsigned sat_lamp_count(input int unsigned count,
                                                   input int unsigned n_lamps);
        return (count > n_lamps) ? n_lamps : count;
    endfunction

endpackage

// File: rtl/lamp_thermometer.sv
// Combinational level -> thermometer decoder: lamp i is lit iff i < level.
module lamp_thermometer #(
    parameter int N_LAMPS = 16,
    parameter int CNT_W   = $clog2(N_LAMPS + 1)
) (
    input  logic [CNT_W-1:0]   level,
    output logic [N_LAMPS-1:0] lights
);

    // Each lamp compares its own index against the lit count.
    always_comb begin
        lights = '0;
        for (int i = 0; i < N_LAMPS; i++) begin
            lights[i] = (level > CNT_W'(i));
        end
    end

endmodule

// File: rtl/lamp_ramp_ctrl.sv
// Lamp ramp controller: walks the lit-lamp count one step per STEP_CYCLES
// clocks toward the latest requested target, reversing direction when
// retargeted. Optional auto-off after HOLD_CYCLES idle clocks is compiled
// in with the LAMP_HOLD_TIMEOUT_EN macro.
module lamp_ramp_ctrl
    import lamp_pkg::*;
#(
    parameter int N_LAMPS     = 16,
    parameter int CNT_W       = $clog2(N_LAMPS + 1),
    parameter int STEP_CYCLES = 4,
    parameter int HOLD_CYCLES = 1024
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic               target_valid,
    input  logic [CNT_W-1:0]   target_count,
    output logic [N_LAMPS-1:0] lights_state,
    output logic [CNT_W-1:0]   level,
    output logic               busy,
    output logic               done
);

    localparam int                STEP_W    = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CYCLES - 1);
    localparam logic [CNT_W-1:0]  LEVEL_MAX = CNT_W'(N_LAMPS);

    lamp_state_t         state;
    lamp_state_t         state_nxt;
    lamp_state_t         desired;
    logic [CNT_W-1:0]    tgt_q;
    logic [CNT_W-1:0]    tgt_nxt;
    logic [CNT_W-1:0]    target_sat;
    logic [CNT_W-1:0]    level_nxt;
    logic [STEP_W-1:0]   step_cnt;
    logic [STEP_W-1:0]   step_nxt;
    logic [N_LAMPS-1:0]  therm_nxt;
    logic                tick;
    logic                done_nxt;
    logic                hold_fire;

    assign target_sat = CNT_W'(sat_lamp_count(int'(unsigned'(target_count)), N_LAMPS));

`ifdef LAMP_HOLD_TIMEOUT_EN
    localparam int               IDLE_W    = $clog2(HOLD_CYCLES + 1);
    localparam logic [IDLE_W-1:0] HOLD_LAST = IDLE_W'(HOLD_CYCLES - 1);

    logic [IDLE_W-1:0] idle_cnt;

    // Auto-off fires once the lamps have sat lit and untouched for HOLD_CYCLES clocks.
    always_comb begin
        hold_fire = (state == IDLE) && (level != '0) && enable && !target_valid &&
                    (idle_cnt == HOLD_LAST);
    end

    // Idle counter: runs only while settled with lamps lit; any new target restarts it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= '0;
        end else if (target_valid || (state != IDLE) || (level == '0) || hold_fire) begin
            idle_cnt <= '0;
        end else if (enable) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end
`else
    // Lamps hold indefinitely: no auto-off.
    assign hold_fire = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: apply any step tick first, then compare the (possibly
    // new) target against the updated level to choose the direction.
    always_comb begin
        tick = (state != IDLE) && enable && (step_cnt == STEP_LAST);

        level_nxt = level;
        if (tick) begin
            if ((state == RAMP_UP) && (level != LEVEL_MAX)) begin
                level_nxt = level + 1'b1;
            end else if ((state == RAMP_DOWN) && (level != '0)) begin
                level_nxt = level - 1'b1;
            end
        end

        tgt_nxt = tgt_q;
        if (target_valid) begin
            tgt_nxt = target_sat;
        end else if (hold_fire) begin
            tgt_nxt = '0;
        end

        if (tgt_nxt > level_nxt) begin
            desired = RAMP_UP;
        end else if (tgt_nxt < level_nxt) begin
            desired = RAMP_DOWN;
        end else begin
            desired = IDLE;
        end

        // While disabled the state freezes; a captured target is acted on later.
        state_nxt = state;
        if (enable) begin
            state_nxt = desired;
        end

        // Step timer restarts on ramp entry and on reversal, otherwise wraps on tick.
        step_nxt = step_cnt;
        if (enable) begin
            if ((state_nxt == IDLE) || (state_nxt != state)) begin
                step_nxt = '0;
            end else if (tick) begin
                step_nxt = '0;
            end else begin
                step_nxt = step_cnt + 1'b1;
            end
        end

        // Settling from a ramp, or a target that already matches while idle.
        done_nxt = ((state != IDLE) && (state_nxt == IDLE)) ||
                   ((state == IDLE) && target_valid && (target_sat == level));
    end

    // Output logic driven from the state register.
    always_comb begin
        busy = (state != IDLE);
    end

    lamp_thermometer #(
        .N_LAMPS (N_LAMPS),
        .CNT_W   (CNT_W)
    ) u_therm (
        .level  (level_nxt),
        .lights (therm_nxt)
    );

    // Level, target, step timer, lamp pattern and done pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level        <= '0;
            tgt_q        <= '0;
            step_cnt     <= '0;
            lights_state <= '0;
            done         <= 1'b0;
        end else begin
            level        <= level_nxt;
            tgt_q        <= tgt_nxt;
            step_cnt     <= step_nxt;
            lights_state <= therm_nxt;
            done         <= done_nxt;
        end
    end

endmodule

// File: tb/tb_lamp_ramp_ctrl.sv
// Directed bench for lamp_ramp_ctrl (N_LAMPS=16, STEP_CYCLES=4, HOLD_CYCLES=8).
// Expected settle levels are queued when a target is driven and popped on done.
module tb_lamp_ramp_ctrl;

    localparam int N  = 16;
    localparam int CW = 5;

    logic          clk;
    logic          rst_n;
    logic          enable;
    logic          target_valid;
    logic [CW-1:0] target_count;
    logic [N-1:0]  lights_state;
    logic [CW-1:0] level;
    logic          busy;
    logic          done;

    int n_total = 0;
    int n_pass  = 0;
    int exp_q[$];

    lamp_ramp_ctrl #(
        .N_LAMPS     (N),
        .CNT_W       (CW),
        .STEP_CYCLES (4),
        .HOLD_CYCLES (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .target_valid (target_valid),
        .target_count (target_count),
        .lights_state (lights_state),
        .level        (level),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_target(input int v);
        target_valid = 1'b1;
        target_count = CW'(v);
        cyc();
        target_valid = 1'b0;
    endtask

    task automatic wait_level(input int exp, input int budget, input string tag);
        int n = 0;
        while (level !== CW'(exp) && n < budget) begin
            cyc();
            n++;
        end
        check(tag, level, exp);
    endtask

    // Scoreboard: every done pulse must match the oldest queued settle level.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && done === 1'b1) begin
            if (exp_q.size() == 0) check("done_spurious", done, 0);
            else check("done_level", level, exp_q.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; enable = 1'b1; target_valid = 1'b0; target_count = '0;
        #2;
        check("rst_lights", lights_state, 0);
        check("rst_level", level, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        cyc(); cyc();
        rst_n = 1'b1;
        cyc();

        // Ramp 0 -> 5, one lamp every 4 clocks.
        exp_q.push_back(5);
        set_target(5);
        check("t5_busy", busy, 1);
        check("t5_level0", level, 0);
        for (int k = 1; k <= 5; k++) begin
            cyc(); cyc(); cyc();
            check("t5_hold", level, k - 1);
            cyc();
            check("t5_step", level, k);
            check("t5_lights", lights_state, (1 << k) - 1);
        end
        check("t5_done", done, 1);
        check("t5_busy_fall", busy, 0);

        // Saturating target 20 -> 16.
        exp_q.push_back(16);
        set_target(20);
        check("t20_done_low", done, 0);
        check("t20_busy", busy, 1);
        wait_level(16, 60, "t20_level");
        check("t20_lights", lights_state, 16'hFFFF);
        check("t20_done", done, 1);
        check("t20_busy_fall", busy, 0);

        // Ramp down to 0.
        exp_q.push_back(0);
        set_target(0);
        wait_level(0, 80, "t0_level");
        check("t0_lights", lights_state, 0);
        check("t0_done", done, 1);

        // Up toward 10, reverse to 2 at level 6.
        set_target(10);
        wait_level(6, 40, "rev_reach6");
        exp_q.push_back(2);
        set_target(2);
        check("rev_level", level, 6);
        check("rev_busy", busy, 1);
        for (int k = 5; k >= 2; k--) begin
            cyc(); cyc(); cyc();
            check("rev_hold", level, k + 1);
            cyc();
            check("rev_step", level, k);
        end
        check("rev_done", done, 1);
        check("rev_busy_fall", busy, 0);

        // Freeze with enable low at level 3.
        exp_q.push_back(8);
        set_target(8);
        wait_level(3, 20, "en_reach3");
        enable = 1'b0;
        for (int i = 0; i < 10; i++) cyc();
        check("en_frozen", level, 3);
        check("en_no_done", done, 0);
        check("en_busy", busy, 1);
        enable = 1'b1;
        cyc(); cyc(); cyc();
        check("en_hold", level, 3);
        cyc();
        check("en_step", level, 4);
        wait_level(8, 30, "en_level8");
        check("en_done", done, 1);

        // Asynchronous reset mid-ramp at level 7.
        set_target(0);
        wait_level(7, 10, "ar_reach7");
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_lights", lights_state, 0);
        check("ar_level", level, 0);
        check("ar_busy", busy, 0);
        check("ar_done", done, 0);
        rst_n = 1'b1;
        exp_q.push_back(0);
        set_target(0);
        check("ar_eq_done", done, 1);
        check("ar_eq_busy", busy, 0);
        cyc();
        check("ar_done_clear", done, 0);

`ifdef LAMP_HOLD_TIMEOUT_EN
        // Auto-off after 8 idle clocks at level 3.
        exp_q.push_back(3);
        set_target(3);
        wait_level(3, 20, "ho_reach3");
        for (int i = 1; i < 8; i++) begin
            cyc();
            check("ho_idle", busy, 0);
        end
        exp_q.push_back(0);
        cyc();
        check("ho_fire", busy, 1);
        check("ho_level", level, 3);
        wait_level(0, 20, "ho_off");
        check("ho_done", done, 1);
`endif

        cyc();
        check("sb_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
